// File: rtl/gb_sdram_pkg.sv
// Shared types and default timing for the GameBoy-to-SDRAM front end and its controller.
package gb_sdram_pkg;

  localparam int unsigned TRCD        = 2;
  localparam int unsigned CAS_LATENCY = 2;

  localparam int unsigned SyncDivDef      = 4;
  localparam int unsigned AccessSlotsDef  = 7;
  localparam int unsigned RefreshSlotsDef = 5;
  localparam int unsigned RefreshClksDef  = 1560;
  localparam int unsigned BootSlotsDef    = 2;

  typedef enum logic [2:0] {
    StBoot,
    StIdle,
    StAccess,
    StDone,
    StHold,
    StRefresh
  } state_e;

  // Byte lane strobe for a byte address: even byte in the low lane, odd byte in the high lane.
  function automatic logic [1:0] lane_ds(input logic byte_sel);
    return byte_sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_sync_gen.sv
// Controller sync strobe divider and periodic refresh interval timer with sticky due flag.
module sdram_sync_gen
  import gb_sdram_pkg::*;
#(
  parameter int unsigned SyncDiv     = SyncDivDef,
  parameter int unsigned RefreshClks = RefreshClksDef
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic init_i,
  input  logic refresh_clr_i,
  output logic sync_o,
  output logic refresh_due_o
);

  localparam int unsigned DivW = (SyncDiv > 2) ? $clog2(SyncDiv) : 1;
  localparam int unsigned RefW = $clog2(RefreshClks);

  logic [DivW-1:0] div_q, div_d;
  logic [RefW-1:0] ref_q, ref_d;
  logic            sync_q, sync_d;
  logic            due_q, due_d;
  logic            div_wrap, ref_wrap;

  assign div_wrap = (div_q == DivW'(SyncDiv - 1));
  assign ref_wrap = (ref_q == RefW'(RefreshClks - 1));

  always_comb begin
    div_d  = div_wrap ? '0 : div_q + 1'b1;
    sync_d = div_wrap;
    ref_d  = ref_wrap ? '0 : ref_q + 1'b1;
    // A wrap in the same cycle as a clear must not lose the new request.
    due_d  = ref_wrap | (due_q & ~refresh_clr_i);
    if (init_i) begin
      ref_d = '0;
      due_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_q  <= '0;
      ref_q  <= '0;
      sync_q <= 1'b0;
      due_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      ref_q  <= ref_d;
      sync_q <= sync_d;
      due_q  <= due_d;
    end
  end

  assign sync_o        = sync_q;
  assign refresh_due_o = due_q;

endmodule

// File: rtl/gb_sdram_bridge.sv
// GameBoy CPU byte bus to SDRAM controller word-request bridge with wait-state generation.
module gb_sdram_bridge
  import gb_sdram_pkg::*;
#(
  parameter int unsigned SyncDiv      = SyncDivDef,
  parameter int unsigned AccessSlots  = AccessSlotsDef,
  parameter int unsigned RefreshSlots = RefreshSlotsDef,
  parameter int unsigned RefreshClks  = RefreshClksDef,
  parameter int unsigned BootSlots    = BootSlotsDef
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        init_i,
  input  logic [23:0] cpu_addr_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_din_i,
  output logic [7:0]  cpu_dout_o,
  output logic        cpu_wait_o,
  output logic        sd_sync_o,
  output logic [23:0] sd_addr_o,
  output logic [1:0]  sd_ds_o,
  output logic [15:0] sd_din_o,
  output logic        sd_oe_o,
  output logic        sd_we_o,
  output logic        sd_refresh_o,
  input  logic [15:0] sd_dout_i
);

  localparam int unsigned MaxAB    = (AccessSlots > BootSlots) ? AccessSlots : BootSlots;
  localparam int unsigned MaxSlots = (MaxAB > RefreshSlots) ? MaxAB : RefreshSlots;
  localparam int unsigned SlotW    = $clog2(MaxSlots + 1);

  state_e           state_q;
  logic [SlotW-1:0] slot_q;
  logic [23:0]      addr_q;
  logic [1:0]       ds_q;
  logic [15:0]      din_q;
  logic [7:0]       dout_q;
  logic             oe_q, we_q, refresh_q;
  logic             sync, refresh_due, refresh_clr, strobe;

  assign strobe      = cpu_rd_i | cpu_wr_i;
  assign refresh_clr = (state_q == StIdle) && !init_i && !strobe && refresh_due;

  sdram_sync_gen #(
    .SyncDiv    (SyncDiv),
    .RefreshClks(RefreshClks)
  ) u_sync_gen (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .init_i       (init_i),
    .refresh_clr_i(refresh_clr),
    .sync_o       (sync),
    .refresh_due_o(refresh_due)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StBoot;
      slot_q    <= '0;
      addr_q    <= '0;
      ds_q      <= 2'b00;
      din_q     <= '0;
      dout_q    <= '0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      refresh_q <= 1'b0;
    end else if (init_i) begin
      state_q   <= StBoot;
      slot_q    <= '0;
      oe_q      <= 1'b0;
      we_q      <= 1'b0;
      refresh_q <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          if (sync) begin
            if (slot_q == SlotW'(BootSlots - 1)) begin
              slot_q  <= '0;
              state_q <= StIdle;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end
        end
        StIdle: begin
          if (strobe) begin
            addr_q  <= cpu_addr_i;
            ds_q    <= lane_ds(cpu_addr_i[0]);
            din_q   <= {cpu_din_i, cpu_din_i};
            we_q    <= cpu_wr_i;
            oe_q    <= ~cpu_wr_i;
            slot_q  <= '0;
            state_q <= StAccess;
          end else if (refresh_due) begin
            refresh_q <= 1'b1;
            slot_q    <= '0;
            state_q   <= StRefresh;
          end
        end
        StAccess: begin
          if (sync) begin
            if (slot_q == SlotW'(AccessSlots - 1)) begin
              dout_q  <= addr_q[0] ? sd_dout_i[15:8] : sd_dout_i[7:0];
              oe_q    <= 1'b0;
              we_q    <= 1'b0;
              slot_q  <= '0;
              state_q <= StDone;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end
        end
        StDone: state_q <= StHold;
        StHold: begin
          // Only a released strobe or a new address may start another access.
          if (!strobe || (cpu_addr_i != addr_q)) state_q <= StIdle;
        end
        StRefresh: begin
          if (sync) begin
            refresh_q <= 1'b0;
            if (slot_q == SlotW'(RefreshSlots - 1)) begin
              slot_q  <= '0;
              state_q <= StIdle;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign cpu_wait_o   = strobe && (state_q != StDone) && (state_q != StHold);
  assign cpu_dout_o   = dout_q;
  assign sd_sync_o    = sync;
  assign sd_addr_o    = {1'b0, addr_q[23:1]};
  assign sd_ds_o      = ds_q;
  assign sd_din_o     = din_q;
  assign sd_oe_o      = oe_q;
  assign sd_we_o      = we_q;
  assign sd_refresh_o = refresh_q;

endmodule
